// File: rtl/f_ifu_fd_if.sv
// Bundle of the fetch-stage buses: the instruction-memory port, the
// D-stage redirect controls and the F/D pipeline register outputs.
interface f_ifu_fd_if;
  // instruction memory port
  logic [31:0] i_inst_addr;
  logic [31:0] i_inst_rdata;
  // D-stage control back into fetch
  logic        stall;
  logic [1:0]  D_npc_op;
  logic        need_b;
  logic [25:0] D_imm26;
  logic [31:0] D_rs_data;
  // F/D register contents and status
  logic [31:0] D_pc;
  logic [31:0] D_instr;
  logic        pc_misalign;

  // fetch unit side
  modport master (
    output i_inst_addr,
    input  i_inst_rdata,
    input  stall,
    input  D_npc_op,
    input  need_b,
    input  D_imm26,
    input  D_rs_data,
    output D_pc,
    output D_instr,
    output pc_misalign
  );

  // instruction memory / decode side
  modport slave (
    input  i_inst_addr,
    output i_inst_rdata,
    output stall,
    output D_npc_op,
    output need_b,
    output D_imm26,
    output D_rs_data,
    input  D_pc,
    input  D_instr,
    input  pc_misalign
  );
endinterface

// File: rtl/f_ifu_fd.sv
// Fetch unit with F/D pipeline register. Holds the fetch PC, selects the
// next PC from the instruction currently in D (delayed-branch, no annul),
// and latches the fetched word into the F/D register.
module f_ifu_fd #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
  input  logic         clk,
  input  logic         reset,   // synchronous, active low
  f_ifu_fd_if.master   bus
);

  localparam logic [1:0] OP_SEQ    = 2'd0;
  localparam logic [1:0] OP_BRANCH = 2'd1;
  localparam logic [1:0] OP_JUMP   = 2'd2;
  localparam logic [1:0] OP_JR     = 2'd3;

  // The F/D register is primed with the slot "before" PC_RESET so that
  // D_pc and F_pc keep their one-instruction spacing out of reset.
  localparam logic [31:0] D_PC_RESET = PC_RESET - 32'd4;

  logic [31:0] f_pc_q, f_pc_d;
  logic [31:0] d_pc_q, d_pc_d;
  logic [31:0] d_instr_q, d_instr_d;
  logic        misalign_q, misalign_d;

  logic [31:0] seq_pc;
  logic [31:0] branch_pc;
  logic [31:0] jump_pc;
  logic [31:0] next_pc;
  logic [31:0] branch_off;

  // Candidate targets; every redirect is relative to the instruction in D.
  always_comb begin
    seq_pc     = f_pc_q + 32'd4;
    branch_off = {{14{bus.D_imm26[15]}}, bus.D_imm26[15:0], 2'b00};
    branch_pc  = d_pc_q + 32'd4 + branch_off;
    jump_pc    = {d_pc_q[31:28], bus.D_imm26, 2'b00};
  end

  // Next-PC select driven by the D-stage decode.
  always_comb begin
    next_pc = seq_pc;
    case (bus.D_npc_op)
      OP_SEQ:    next_pc = seq_pc;
      OP_BRANCH: next_pc = bus.need_b ? branch_pc : seq_pc;
      OP_JUMP:   next_pc = jump_pc;
      OP_JR:     next_pc = bus.D_rs_data;
      default:   next_pc = seq_pc;
    endcase
  end

  // Pipeline advance: a stall freezes everything, so a redirect decided in
  // a stalled cycle is simply re-evaluated once the stall drops.
  always_comb begin
    f_pc_d     = f_pc_q;
    d_pc_d     = d_pc_q;
    d_instr_d  = d_instr_q;
    misalign_d = misalign_q;
    if (!bus.stall) begin
      f_pc_d     = next_pc;
      d_pc_d     = f_pc_q;
      d_instr_d  = bus.i_inst_rdata;
      misalign_d = |next_pc[1:0];
    end
  end

  // State registers; reset wins over stall and redirect.
  always_ff @(posedge clk) begin
    if (!reset) begin
      f_pc_q     <= PC_RESET;
      d_pc_q     <= D_PC_RESET;
      d_instr_q  <= 32'd0;
      misalign_q <= 1'b0;
    end else begin
      f_pc_q     <= f_pc_d;
      d_pc_q     <= d_pc_d;
      d_instr_q  <= d_instr_d;
      misalign_q <= misalign_d;
    end
  end

  assign bus.i_inst_addr = f_pc_q;
  assign bus.D_pc        = d_pc_q;
  assign bus.D_instr     = d_instr_q;
  assign bus.pc_misalign = misalign_q;

endmodule

// File: tb/tb_f_ifu_fd.sv
// Scoreboard bench for f_ifu_fd: each stimulus step queues the state
// expected after the next rising edge; a monitor pops and compares.
module tb_f_ifu_fd;
  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  f_ifu_fd_if bus ();

  f_ifu_fd #(.PC_RESET(32'h0000_3000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // instruction memory model: word is a simple function of its address
  function automatic logic [31:0] imem(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  assign bus.i_inst_rdata = imem(bus.i_inst_addr);

  typedef struct {
    string       nm;
    logic [31:0] f_pc;
    logic [31:0] d_pc;
    logic [31:0] d_instr;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string nm, input string fld,
                     input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s.%s got=%08h want=%08h", nm, fld, act, req);
    end
  endtask

  // monitor: every cycle after the edge, compare against the oldest entry
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk(e.nm, "f_pc",    bus.i_inst_addr,        e.f_pc);
      chk(e.nm, "d_pc",    bus.D_pc,               e.d_pc);
      chk(e.nm, "d_instr", bus.D_instr,            e.d_instr);
      chk(e.nm, "misalgn", {31'd0, bus.pc_misalign}, {31'd0, e.mis});
      $display("[TB] %-10s F=%08h D=%08h I=%08h M=%0b", e.nm,
               bus.i_inst_addr, bus.D_pc, bus.D_instr, bus.pc_misalign);
    end
  end

  task automatic step(input logic rn, input logic st, input logic [1:0] op,
                      input logic nb, input logic [25:0] imm,
                      input logic [31:0] rs, input logic [31:0] ef,
                      input logic [31:0] ed, input logic [31:0] ei,
                      input logic em, input string nm);
    exp_t e;
    @(negedge clk);
    reset         = rn;
    bus.stall     = st;
    bus.D_npc_op  = op;
    bus.need_b    = nb;
    bus.D_imm26   = imm;
    bus.D_rs_data = rs;
    e.nm = nm; e.f_pc = ef; e.d_pc = ed; e.d_instr = ei; e.mis = em;
    exp_q.push_back(e);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset         = 1'b0;
    bus.stall     = 1'b0;
    bus.D_npc_op  = 2'd0;
    bus.need_b    = 1'b0;
    bus.D_imm26   = 26'd0;
    bus.D_rs_data = 32'd0;

    //    rn  st  op  nb  imm26          rs             F_pc           D_pc           D_instr              M
    step(0, 1, 1, 1, 26'h000FFFE, 32'h0,         32'h0000_3000, 32'h0000_2FFC, 32'h0,               0, "rst_ovr");
    step(0, 0, 0, 0, 26'h0,       32'h0,         32'h0000_3000, 32'h0000_2FFC, 32'h0,               0, "rst_hold");
    step(1, 0, 0, 0, 26'h0,       32'h0,         32'h0000_3004, 32'h0000_3000, imem(32'h0000_3000), 0, "seq0");
    step(1, 0, 0, 0, 26'h0,       32'h0,         32'h0000_3008, 32'h0000_3004, imem(32'h0000_3004), 0, "seq1");
    // D_pc=3004 branch taken, offset -2 words -> 3000; delay slot 3008 enters D
    step(1, 0, 1, 1, 26'h000FFFE, 32'h0,         32'h0000_3000, 32'h0000_3008, imem(32'h0000_3008), 0, "br_taken");
    step(1, 0, 1, 0, 26'h000FFFE, 32'h0,         32'h0000_3004, 32'h0000_3000, imem(32'h0000_3000), 0, "br_nt");
    step(1, 0, 0, 0, 26'h0,       32'h0,         32'h0000_3008, 32'h0000_3004, imem(32'h0000_3004), 0, "seq2");
    step(1, 0, 0, 0, 26'h0,       32'h0,         32'h0000_300C, 32'h0000_3008, imem(32'h0000_3008), 0, "seq3");
    step(1, 0, 0, 0, 26'h0,       32'h0,         32'h0000_3010, 32'h0000_300C, imem(32'h0000_300C), 0, "seq4");
    step(1, 0, 0, 0, 26'h0,       32'h0,         32'h0000_3014, 32'h0000_3010, imem(32'h0000_3010), 0, "seq5");
    // D_pc=3010 jump to 3040; 3014 still reaches D
    step(1, 0, 2, 0, 26'h0000C10, 32'h0,         32'h0000_3040, 32'h0000_3014, imem(32'h0000_3014), 0, "jump");
    // jump in the delay slot, from its own D_pc=3014
    step(1, 0, 2, 0, 26'h0000C20, 32'h0,         32'h0000_3080, 32'h0000_3040, imem(32'h0000_3040), 0, "jump_b2b");
    step(1, 0, 0, 0, 26'h0,       32'h0,         32'h0000_3084, 32'h0000_3080, imem(32'h0000_3080), 0, "seq6");
    // stall for three cycles, redirect inputs changing underneath
    step(1, 1, 3, 0, 26'h0,       32'h0000_3100, 32'h0000_3084, 32'h0000_3080, imem(32'h0000_3080), 0, "stall0");
    step(1, 1, 1, 1, 26'h000FFFE, 32'h0000_3100, 32'h0000_3084, 32'h0000_3080, imem(32'h0000_3080), 0, "stall1");
    step(1, 1, 3, 0, 26'h0,       32'h0000_3100, 32'h0000_3084, 32'h0000_3080, imem(32'h0000_3080), 0, "stall2");
    step(1, 0, 3, 0, 26'h0,       32'h0000_3100, 32'h0000_3100, 32'h0000_3084, imem(32'h0000_3084), 0, "jr");
    step(1, 0, 3, 0, 26'h0,       32'h0000_3102, 32'h0000_3102, 32'h0000_3100, imem(32'h0000_3100), 1, "jr_mis");
    step(1, 0, 0, 0, 26'h0,       32'h0,         32'h0000_3106, 32'h0000_3102, imem(32'h0000_3102), 1, "seq_mis");
    step(1, 0, 3, 0, 26'h0,       32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_3106, imem(32'h0000_3106), 0, "jr_top");
    step(1, 0, 0, 0, 26'h0,       32'h0,         32'h0000_0000, 32'hFFFF_FFFC, imem(32'hFFFF_FFFC), 0, "wrap");
    // reset during stall with a pending taken branch
    step(0, 1, 1, 1, 26'h000FFFE, 32'h0,         32'h0000_3000, 32'h0000_2FFC, 32'h0,               0, "rst_stall");
    step(1, 1, 0, 0, 26'h0,       32'h0,         32'h0000_3000, 32'h0000_2FFC, 32'h0,               0, "post_stall");
    step(1, 0, 0, 0, 26'h0,       32'h0,         32'h0000_3004, 32'h0000_3000, imem(32'h0000_3000), 0, "post_run");

    repeat (3) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // watchdog
  initial begin
    #100000;
    $display("FAIL watchdog time=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
